// File: rtl/imu_poll_ctrl_if.sv
// imu_poll_ctrl_if: bus between the accelerometer sequencer and the 8-bit SPI transaction engine.
//   addr/wdata/read : transaction descriptor, stable from the enable pulse until done
//   enable          : one-cycle start pulse to the engine
//   done/rdata      : one-cycle completion strobe; rdata is valid in the same cycle
interface imu_poll_ctrl_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       read;
    logic       enable;
    logic       done;
    logic [7:0] rdata;
    modport master (output addr, wdata, read, enable, input done, rdata);
    modport slave  (input addr, wdata, read, enable, output done, rdata);
endinterface

// File: rtl/imu_poll_ctrl.sv
// imu_poll_ctrl: checks the accelerometer ID, writes two config registers, then polls X/Y/Z every POLL_DIV cycles.
//   clk, reset          : clock, synchronous active-high reset
//   run                 : polling enable; when low, the current burst finishes and the next one is held
//   spi                 : master side of the SPI transaction engine
//   accel_x/y/z         : latest signed 16-bit sample {H,L}
//   sample_valid        : one-cycle pulse when all three axes update
//   busy                : a transaction is outstanding
//   id_err              : sticky ID mismatch flag, cleared by a good ID read
module imu_poll_ctrl #(
    parameter int         POLL_DIV  = 50000,
    parameter logic [7:0] ID_ADDR   = 8'h0F,
    parameter logic [7:0] ID_VAL    = 8'h33,
    parameter logic [7:0] CFG1_ADDR = 8'h20,
    parameter logic [7:0] CFG1_DATA = 8'h57,
    parameter logic [7:0] CFG2_ADDR = 8'h23,
    parameter logic [7:0] CFG2_DATA = 8'h08,
    parameter logic [7:0] DATA_ADDR = 8'h28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    imu_poll_ctrl_if.master       spi,
    output logic [15:0]           accel_x,
    output logic [15:0]           accel_y,
    output logic [15:0]           accel_z,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  id_err
);
    localparam int CW = $clog2(POLL_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(POLL_DIV - 1);

    typedef enum logic [3:0] {
        ID_ISSUE, ID_WAIT, CFG1_ISSUE, CFG1_WAIT, CFG2_ISSUE, CFG2_WAIT,
        IDLE_WAIT, RD_ISSUE, RD_WAIT, PUBLISH, ERR_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    rd_buf [6];
    logic          is_issue, is_wait, iss_read, done_ok;
    logic [7:0]    iss_addr, iss_wdata;

    always_comb begin
        is_issue  = state inside {ID_ISSUE, CFG1_ISSUE, CFG2_ISSUE, RD_ISSUE};
        is_wait   = state inside {ID_WAIT, CFG1_WAIT, CFG2_WAIT, RD_WAIT};
        iss_addr  = state == ID_ISSUE   ? ID_ADDR   :
                    state == CFG1_ISSUE ? CFG1_ADDR :
                    state == CFG2_ISSUE ? CFG2_ADDR : DATA_ADDR + {5'd0, idx};
        iss_wdata = state == CFG1_ISSUE ? CFG1_DATA :
                    state == CFG2_ISSUE ? CFG2_DATA : 8'h00;
        iss_read  = !(state inside {CFG1_ISSUE, CFG2_ISSUE});
        // busy is only set one cycle after the enable pulse, so a stale done
        // left over from before a reset can never complete a new transaction
        done_ok   = busy && spi.done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ID_ISSUE;
            spi.enable   <= 1'b0;
            spi.read     <= 1'b0;
            spi.addr     <= 8'h00;
            spi.wdata    <= 8'h00;
            accel_x      <= 16'h0000;
            accel_y      <= 16'h0000;
            accel_z      <= 16'h0000;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            id_err       <= 1'b0;
            cnt          <= '0;
            idx          <= 3'd0;
        end else begin
            spi.enable   <= is_issue;
            sample_valid <= 1'b0;
            if (is_issue) begin
                spi.addr  <= iss_addr;
                spi.wdata <= iss_wdata;
                spi.read  <= iss_read;
            end
            if (is_wait)
                busy <= !done_ok;
            case (state)
                ID_ISSUE:   state <= ID_WAIT;
                CFG1_ISSUE: state <= CFG1_WAIT;
                CFG2_ISSUE: state <= CFG2_WAIT;
                RD_ISSUE:   state <= RD_WAIT;
                ID_WAIT: if (done_ok) begin
                    id_err <= spi.rdata != ID_VAL;
                    state  <= spi.rdata == ID_VAL ? CFG1_ISSUE : ERR_WAIT;
                    cnt    <= '0;
                end
                CFG1_WAIT: if (done_ok) state <= CFG2_ISSUE;
                CFG2_WAIT: if (done_ok) begin
                    state <= IDLE_WAIT;
                    cnt   <= '0;
                end
                // counter saturates at its last value while run is low
                IDLE_WAIT: if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    else if (run) begin
                        state <= RD_ISSUE;
                        idx   <= 3'd0;
                    end
                RD_WAIT: if (done_ok) begin
                    rd_buf[idx] <= spi.rdata;
                    idx         <= idx + 3'd1;
                    state       <= idx == 3'd5 ? PUBLISH : RD_ISSUE;
                end
                PUBLISH: begin
                    accel_x      <= {rd_buf[1], rd_buf[0]};
                    accel_y      <= {rd_buf[3], rd_buf[2]};
                    accel_z      <= {rd_buf[5], rd_buf[4]};
                    sample_valid <= 1'b1;
                    cnt          <= '0;
                    state        <= IDLE_WAIT;
                end
                ERR_WAIT: if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    else begin
                        cnt   <= '0;
                        state <= ID_ISSUE;
                    end
                default: state <= ID_ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_imu_poll_ctrl.sv
// tb_imu_poll_ctrl: scoreboard bench with a 34-cycle SPI engine model for imu_poll_ctrl.
module tb_imu_poll_ctrl;
    localparam int PD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, busy, id_err;

    imu_poll_ctrl_if spi ();

    imu_poll_ctrl #(.POLL_DIV(PD)) dut (
        .clk(clk), .reset(reset), .run(run), .spi(spi),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .sample_valid(sample_valid), .busy(busy), .id_err(id_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [16:0] exp_txn [$];
    logic [47:0] exp_smp [$];
    logic [7:0]  regs [256];
    int          en_count = 0;
    int          smp_count = 0;
    int          busy_left = 0;
    logic        prev_en = 1'b0;
    logic [7:0]  cur_addr = 8'h00;

    // engine model: a new enable restarts it; done arrives 34 cycles after enable
    initial begin
        spi.done  = 1'b0;
        spi.rdata = 8'h00;
        forever begin
            @(negedge clk);
            spi.done = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    spi.done  = 1'b1;
                    spi.rdata = regs[cur_addr];
                end
            end
            if (spi.enable) begin
                busy_left = 33;
                cur_addr  = spi.addr;
            end
        end
    end

    always @(negedge clk) begin
        if (spi.enable) begin
            en_count++;
            check("en_busy", busy, 0);
            check("en_width", prev_en, 0);
            check("txn_pending", exp_txn.size() > 0, 1);
            if (exp_txn.size() > 0)
                check("txn", {spi.read, spi.addr, spi.wdata}, exp_txn.pop_front());
        end
        if (sample_valid) begin
            smp_count++;
            check("smp_pending", exp_smp.size() > 0, 1);
            if (exp_smp.size() > 0)
                check("sample", {accel_x, accel_y, accel_z}, exp_smp.pop_front());
        end
        prev_en = spi.enable;
    end

    task automatic push_rd(input logic [7:0] a);
        exp_txn.push_back({1'b1, a, 8'h00});
    endtask

    task automatic push_init();
        push_rd(8'h0F);
        exp_txn.push_back({1'b0, 8'h20, 8'h57});
        exp_txn.push_back({1'b0, 8'h23, 8'h08});
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) push_rd(8'h28 + 8'(i));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_txn.size() > 0 || busy_left > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_txn.size(), 0);
    endtask

    task automatic wait_en(input int target, input string tag);
        int n = 0;
        while (en_count < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, en_count >= target, 1);
    endtask

    task automatic wait_smp(input int target, input string tag);
        int n = 0;
        while (smp_count < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, smp_count >= target, 1);
    endtask

    task automatic set_bytes(input logic [47:0] b);
        for (int i = 0; i < 6; i++) regs[8'h28 + 8'(i)] = b[8*i +: 8];
    endtask

    initial begin
        int n0;
        int n;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h0F] = 8'h33;
        repeat (3) @(negedge clk);
        check("rst_enable", spi.enable, 0);
        check("rst_addr", spi.addr, 0);
        check("rst_wdata", spi.wdata, 0);
        check("rst_read", spi.read, 0);
        check("rst_busy", busy, 0);
        check("rst_id_err", id_err, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_accel", {accel_x, accel_y, accel_z}, 0);

        push_init();
        reset = 1'b0;
        wait_drain("init_done");
        repeat (5) @(negedge clk);
        check("id_err_ok", id_err, 0);

        n0 = en_count;
        repeat (1000) @(negedge clk);
        check("no_rd_run0", en_count - n0, 0);

        // bytes listed high-index first: 80,00,FF,FF,12,34
        set_bytes(48'h8000_FFFF_1234);
        push_burst(6);
        push_burst(6);
        exp_smp.push_back({16'h1234, 16'hFFFF, 16'h8000});
        n0 = en_count;
        run = 1'b1;
        n = 0;
        while (en_count == n0 && n < PD + 10) begin
            @(negedge clk);
            n++;
        end
        check("first_rd_seen", en_count > n0, 1);
        check("first_rd_lat", n <= PD + 2, 1);
        wait_smp(1, "smp1_seen");
        set_bytes(48'h0605_0403_0201);
        exp_smp.push_back({16'h0201, 16'h0403, 16'h0605});
        wait_en(n0 + 9, "third_rd_seen");
        run = 1'b0;
        wait_smp(2, "smp2_seen");
        wait_drain("burst2_done");
        check("hold_x", accel_x, 16'h0201);
        check("hold_z", accel_z, 16'h0605);
        n0 = en_count;
        repeat (1000) @(negedge clk);
        check("no_rd_after_drop", en_count - n0, 0);
        check("one_smp_after_drop", smp_count, 2);

        push_burst(4);
        n0 = en_count;
        run = 1'b1;
        wait_en(n0 + 4, "rd_idx3_seen");
        repeat (10) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_accel", {accel_x, accel_y, accel_z}, 0);
        check("mid_rst_busy", busy, 0);
        push_init();
        reset = 1'b0;
        wait_drain("reinit_done");
        check("no_partial_publish", smp_count, 2);

        regs[8'h0F] = 8'h00;
        push_rd(8'h0F);
        n0 = en_count;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_en(n0 + 1, "id_rd_seen");
        n = 0;
        while (!spi.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("id_err_set", id_err, 1);
        regs[8'h0F] = 8'h33;
        push_init();
        wait_drain("retry_done");
        repeat (3) @(negedge clk);
        check("id_err_clear", id_err, 0);
        check("smp_left", exp_smp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
